ring_counter_n: RTL and testbench

Parametrised synchronous ring/Johnson counter: a WIDTH-bit shift register whose state recirculates, either as a one-hot ring or as a twisted-ring (Johnson) sequence. Direction is selectable, the state is parallel-loadable, illegal states are detected and optionally self-corrected, and a one-cycle wrap strobe is produced. It is the general sequencer/phase generator for the design's timing and scanning logic, and replaces fixed 4-bit rings built from individually preset/cleared flip-flops.

---
 rtl/ring_counter_n.sv | 101 ++++++++++
 tb/tb_ring_counter_n.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_n.sv
// ring_counter_n: parametrised ring / Johnson (twisted-ring) counter.
// The state can step in either direction, can be loaded in parallel, is
// checked for legality against the current mode (with optional self-correction),
// and raises a one-cycle wrap strobe whenever a step lands on the home state.
module ring_counter_n #(
  parameter int WIDTH        = 4,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic             MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP,
  output logic             ILLEGAL
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] shifted;
  logic             fb;
  logic             ring_legal, john_legal;

  // Home is the single set LSB in ring mode and all-zero in Johnson mode.
  assign home = MODE ? {WIDTH{1'b0}} : {{(WIDTH-1){1'b0}}, 1'b1};

  // Legality, using saturating "seen one / seen two" flags instead of counters:
  // ring needs exactly one bit set, Johnson needs at most one 0/1 transition.
  always_comb begin
    logic seen1_r, seen2_r, seen1_j, seen2_j;
    seen1_r = 1'b0;
    seen2_r = 1'b0;
    seen1_j = 1'b0;
    seen2_j = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_q[i]) begin
        if (seen1_r) seen2_r = 1'b1;
        seen1_r = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH-1; i++) begin
      if (q_q[i] ^ q_q[i+1]) begin
        if (seen1_j) seen2_j = 1'b1;
        seen1_j = 1'b1;
      end
    end
    ring_legal = seen1_r & ~seen2_r;
    john_legal = ~seen2_j;
  end

  assign ILLEGAL = MODE ? ~john_legal : ~ring_legal;

  // Shift equations: the bit fed in is the bit falling off the other end,
  // inverted in Johnson mode.
  always_comb begin
    fb      = 1'b0;
    shifted = q_q;
    if (!DIR) begin
      fb      = MODE ? ~q_q[WIDTH-1] : q_q[WIDTH-1];
      shifted = {q_q[WIDTH-2:0], fb};
    end else begin
      fb      = MODE ? ~q_q[0] : q_q[0];
      shifted = {fb, q_q[WIDTH-1:1]};
    end
  end

  // Next state: load beats step beats hold; wrap only from a genuine shift.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (LOAD) begin
      q_d = D;
    end else if (EN) begin
      if (ILLEGAL && SELF_CORRECT) begin
        q_d = home;
      end else begin
        q_d    = shifted;
        wrap_d = (shifted == home);
      end
    end
  end

  // State register with synchronous reset to the home of the sampled MODE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= home;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_ring_counter_n.sv
// Directed bench for ring_counter_n: a self-correcting and a non-correcting
// 4-bit instance plus an 8-bit instance, all on shared controls.
module tb_ring_counter_n;

  logic       clk;
  logic       rst, en, dir, mode, load;
  logic [3:0] d4;
  logic [7:0] d8;
  logic [3:0] q4, q4n;
  logic [7:0] q8;
  logic       wrap4, wrap4n, wrap8;
  logic       ill4, ill4n, ill8;

  int n_cmp;
  int n_bad;

  ring_counter_n #(.WIDTH(4), .SELF_CORRECT(1'b1)) u_w4 (
    .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .MODE(mode), .LOAD(load),
    .D(d4), .Q(q4), .WRAP(wrap4), .ILLEGAL(ill4)
  );

  ring_counter_n #(.WIDTH(4), .SELF_CORRECT(1'b0)) u_w4nc (
    .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .MODE(mode), .LOAD(load),
    .D(d4), .Q(q4n), .WRAP(wrap4n), .ILLEGAL(ill4n)
  );

  ring_counter_n #(.WIDTH(8), .SELF_CORRECT(1'b1)) u_w8 (
    .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .MODE(mode), .LOAD(load),
    .D(d8), .Q(q8), .WRAP(wrap8), .ILLEGAL(ill8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] ring_up   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] john_up   [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] ring_down [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [7:0] john8     [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  initial begin
    int wraps;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
    d4 = '0; d8 = '0;
    @(negedge clk);

    // Ring up from reset
    step();
    chk("rst_q", q4, 4'b0001);
    chk("rst_wrap", wrap4, 0);
    chk("rst_ill", ill4, 0);
    rst = 1'b0; en = 1'b1;
    wraps = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ring_up_q%0d", i), q4, ring_up[i]);
      chk($sformatf("ring_up_wrap%0d", i), wrap4, (i == 3));
      chk($sformatf("ring_up_ill%0d", i), ill4, 0);
    end

    // Johnson up from reset
    mode = 1'b1; rst = 1'b1;
    step();
    chk("john_rst_q", q4, 4'b0000);
    chk("john_rst_ill", ill4, 0);
    // Zero-latency illegal: all-zero is not a legal ring state
    mode = 1'b0;
    #1;
    chk("ill_comb_mode", ill4, 1);
    mode = 1'b1;
    #1;
    chk("ill_comb_back", ill4, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("john_up_q%0d", i), q4, john_up[i]);
      chk($sformatf("john_up_wrap%0d", i), wrap4, (i == 7));
    end

    // Ring down, then reverse direction at 0100
    mode = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ring_dn_q%0d", i), q4, ring_down[i]);
      chk($sformatf("ring_dn_wrap%0d", i), wrap4, (i == 3));
    end
    step();
    chk("ring_dn_q4", q4, 4'b1000);
    chk("ring_dn_wrap4", wrap4, 0);
    step();
    chk("ring_dn_q5", q4, 4'b0100);
    dir = 1'b0;
    step();
    chk("dir_flip_q", q4, 4'b1000);
    chk("dir_flip_wrap", wrap4, 0);

    // Illegal load and correction behaviour
    en = 1'b0; load = 1'b1; d4 = 4'b0110;
    step();
    chk("ld_q_sc", q4, 4'b0110);
    chk("ld_ill_sc", ill4, 1);
    chk("ld_q_nc", q4n, 4'b0110);
    chk("ld_ill_nc", ill4n, 1);
    chk("ld_wrap", wrap4, 0);
    load = 1'b0; en = 1'b1;
    step();
    chk("corr_q", q4, 4'b0001);
    chk("corr_wrap", wrap4, 0);
    chk("corr_ill", ill4, 0);
    chk("nocorr_q", q4n, 4'b1100);
    chk("nocorr_ill", ill4n, 1);
    chk("nocorr_wrap", wrap4n, 0);

    // Johnson-illegal pattern
    en = 1'b0; load = 1'b1; mode = 1'b1; d4 = 4'b0101;
    step();
    chk("john_ill", ill4, 1);
    mode = 1'b0;

    // Priority: reset over load, load over step, hold
    rst = 1'b1; load = 1'b1; d4 = 4'b1000;
    step();
    chk("rst_over_ld", q4, 4'b0001);
    rst = 1'b0; load = 1'b1; en = 1'b1; d4 = 4'b0100;
    step();
    chk("ld_over_en", q4, 4'b0100);
    chk("ld_over_en_wrap", wrap4, 0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_q%0d", i), q4, 4'b0100);
      chk($sformatf("hold_wrap%0d", i), wrap4, 0);
    end

    // Wrap lasts one cycle when followed by a hold
    load = 1'b1; d4 = 4'b1000;
    step();
    load = 1'b0; en = 1'b1;
    step();
    chk("wrap_hit_q", q4, 4'b0001);
    chk("wrap_hit", wrap4, 1);
    en = 1'b0;
    step();
    chk("wrap_drop", wrap4, 0);

    // Mode switch on a state legal in both modes continues without correction
    mode = 1'b1; en = 1'b1;
    step();
    chk("mode_sw_q", q4, 4'b0011);

    // Johnson reverse from home
    rst = 1'b1;
    step();
    rst = 1'b0; dir = 1'b1;
    step();
    chk("john_dn_q", q4, 4'b1000);
    dir = 1'b0;

    // 8-bit Johnson with a mid-run reset
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("w8_pre_q", q8, 8'h0F);
    rst = 1'b1;
    step();
    chk("w8_rst_q", q8, 8'h00);
    chk("w8_rst_wrap", wrap8, 0);
    rst = 1'b0;
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("w8_q%0d", i), q8, john8[i]);
      chk($sformatf("w8_ill%0d", i), ill8, 0);
      if (wrap8) wraps++;
    end
    chk("w8_last_wrap", wrap8, 1);
    chk("w8_wrap_count", wraps, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
